accum_loop_ctrl: RTL

Multi-cycle sequencer for the alternating add/subtract accumulate datapath. It accepts one (A, B) operand pair per transaction over a valid/ready handshake. It then runs COUNT accumulate steps, one per clock: even steps add A+B, odd steps add A−B. It returns the accumulator minus OFFSET on a valid/ready output port. It replaces the fully unrolled single-cycle form where timing or area forbids unrolling, and sits between an operand producer and a result consumer.

---
 rtl/accum_loop_pkg.sv | 27 ++
 rtl/accum_loop_step.sv | 17 +
 rtl/accum_loop_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/accum_loop_pkg.sv
// Shared types, default constants and the wrapped add/sub step function for the
// alternating accumulate sequencer.
package accum_loop_pkg;

   localparam int unsigned DEF_W      = 8;
   localparam int unsigned DEF_COUNT  = 4;
   localparam int unsigned DEF_INIT   = 1;
   localparam int unsigned DEF_OFFSET = 17;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   // Evaluated at 64 bits; callers truncate to W, which is exact because
   // modular add/sub never carries information downward (W <= 64).
   function automatic logic [63:0] step_op(input logic [63:0] acc,
                                           input logic [63:0] a,
                                           input logic [63:0] b,
                                           input logic        odd);
      logic [63:0] term;
      term    = odd ? (a - b) : (a + b);
      step_op = acc + term;
   endfunction

endpackage

// File: rtl/accum_loop_step.sv
// Combinational accumulate step: acc + (a+b) on even steps, acc + (a-b) on odd
// steps, all modulo 2^W.
module accum_loop_step
   import accum_loop_pkg::*;
#(
   parameter int unsigned W = DEF_W
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         odd,
   output logic [W-1:0] acc_next
);

   assign acc_next = W'(step_op(64'(acc), 64'(a), 64'(b), odd));

endmodule

// File: rtl/accum_loop_ctrl.sv
// Multi-cycle alternating add/sub accumulate sequencer with valid/ready ports.
// Define ACCUM_LOOP_PERSIST_EN to carry the accumulator across transactions.
module accum_loop_ctrl
   import accum_loop_pkg::*;
#(
   parameter int unsigned W      = DEF_W,
   parameter int unsigned COUNT  = DEF_COUNT,
   parameter int unsigned INIT   = DEF_INIT,
   parameter int unsigned OFFSET = DEF_OFFSET
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] xout,
   output logic         busy
);

   localparam int unsigned KW = $clog2(COUNT + 1);

   state_e        state_q, state_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [KW-1:0] k_q, k_d;
   logic [W-1:0]  xout_q, xout_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  acc_next;

   accum_loop_step #(
      .W (W)
   ) u_step (
      .acc      (acc_q),
      .a        (a_q),
      .b        (b_q),
      .odd      (k_q[0]),
      .acc_next (acc_next)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      a_d         = a_q;
      b_d         = b_q;
      k_d         = k_q;
      xout_d      = xout_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               k_d     = '0;
`ifndef ACCUM_LOOP_PERSIST_EN
               acc_d   = W'(INIT);
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_next;
            k_d   = k_q + KW'(1);
            if (k_q == KW'(COUNT - 1)) begin
               xout_d      = acc_next - W'(OFFSET);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= W'(INIT);
         a_q         <= '0;
         b_q         <= '0;
         k_q         <= '0;
         xout_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         a_q         <= a_d;
         b_q         <= b_d;
         k_q         <= k_d;
         xout_q      <= xout_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Handshake input is held off while reset is asserted.
   assign in_ready  = (state_q == IDLE) && rst_n;
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign xout      = xout_q;

endmodule
